// File: rtl/csr_file.sv
// Machine/supervisor CSR file beside execute/commit: combinational read, registered write,
// trap entry with optional S-mode delegation, xRET sequencing and a one-cycle PC redirect.
module csr_file #(
    parameter int              XLEN          = 64,
    parameter logic [XLEN-1:0] HART_ID       = '0,
    parameter bit              HAS_SMODE     = 1'b1,
    parameter bit              VECTORED_EN   = 1'b1,
    parameter logic [63:0]     MEDELEG_WMASK = 64'hb3ff,
    parameter logic [63:0]     MIDELEG_WMASK = 64'h222
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            csr_we,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            sret,
    input  logic [XLEN-1:0] ext_irq_mip,
    output logic            irq_pending,
    output logic [1:0]      priv,
    output logic [XLEN-1:0] satp_q,
    output logic [XLEN-1:0] mstatus_q,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam logic [63:0] SSTATUS_M64 = 64'h8000_0003_0001_e000;
    localparam logic [63:0] MSTATUS_M64 = 64'h7e_79bb;
    localparam logic [63:0] MIP_M64     = 64'h333;
    localparam logic [63:0] MEDELEG_M64 = MEDELEG_WMASK & ~64'h800;
    localparam logic [XLEN-1:0] SSTATUS_MASK = SSTATUS_M64[XLEN-1:0];
    localparam logic [XLEN-1:0] MSTATUS_MASK = MSTATUS_M64[XLEN-1:0];
    localparam logic [XLEN-1:0] MIP_MASK     = MIP_M64[XLEN-1:0];
    localparam logic [XLEN-1:0] MEDELEG_MASK = MEDELEG_M64[XLEN-1:0];
    localparam logic [XLEN-1:0] MIDELEG_MASK = MIDELEG_WMASK[XLEN-1:0];
    localparam int SIE = 1, MIE = 3, SPIE = 5, MPIE = 7, SPP = 8;
    localparam logic [1:0] PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11;

    logic [XLEN-1:0] mstatus, medeleg, mideleg, mie, mtvec, mscratch, mepc, mcause, mtval, mip;
    logic [XLEN-1:0] mcycle, sscratch, sepc, scause, stval, stvec, satp;
    logic [1:0]      priv_q;

    logic [XLEN-1:0] mip_rd, rd, wval, tvec_sel, target;
    logic [63:0]     deleg64;
    logic            impl, illegal, do_write, deleg, mret_ok, sret_ok, intr;

    function automatic logic [XLEN-1:0] tvec_fix(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r    = v;
        r[1] = 1'b0;
        if (!VECTORED_EN) r[0] = 1'b0;
        return r;
    endfunction

    assign mip_rd = mip | ext_irq_mip;

    always_comb begin
        rd   = '0;
        impl = 1'b1;
        case (csr_addr)
            12'h300: rd = mstatus;
            12'h302: begin rd = medeleg; impl = HAS_SMODE; end
            12'h303: begin rd = mideleg; impl = HAS_SMODE; end
            12'h304: rd = mie;
            12'h305: rd = mtvec;
            12'h340: rd = mscratch;
            12'h341: rd = mepc;
            12'h342: rd = mcause;
            12'h343: rd = mtval;
            12'h344: rd = mip_rd;
            12'hb00: rd = mcycle;
            12'hf14: rd = HART_ID;
            12'h100: begin rd = mstatus & SSTATUS_MASK; impl = HAS_SMODE; end
            12'h104: begin rd = mie & mideleg; impl = HAS_SMODE; end
            12'h105: begin rd = stvec; impl = HAS_SMODE; end
            12'h140: begin rd = sscratch; impl = HAS_SMODE; end
            12'h141: begin rd = sepc; impl = HAS_SMODE; end
            12'h142: begin rd = scause; impl = HAS_SMODE; end
            12'h143: begin rd = stval; impl = HAS_SMODE; end
            12'h144: begin rd = mip_rd & mideleg; impl = HAS_SMODE; end
            12'h180: begin rd = satp; impl = HAS_SMODE; end
            default: impl = 1'b0;
        endcase
    end

    assign illegal = !impl || (csr_addr[9:8] > priv_q) ||
                     (csr_we && csr_op != 2'b00 && csr_addr[11:10] == 2'b11);
    assign csr_illegal = illegal;
    assign csr_rdata   = illegal ? '0 : rd;

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rd | csr_wdata;
            2'b11:   wval = rd & ~csr_wdata;
            default: wval = rd;
        endcase
    end

    // A raw trap/xRET request blocks lower-priority work even if it is itself ignored.
    assign mret_ok  = mret && !trap_valid && priv_q == PRIV_M;
    assign sret_ok  = sret && !trap_valid && !mret && priv_q != PRIV_U;
    assign do_write = csr_we && csr_op != 2'b00 && !illegal && !trap_valid && !mret && !sret;

    assign intr     = trap_cause[XLEN-1];
    assign deleg64  = 64'(intr ? mideleg : medeleg);
    assign deleg    = HAS_SMODE && priv_q != PRIV_M && deleg64[trap_cause[5:0]];
    assign tvec_sel = deleg ? stvec : mtvec;
    assign target   = {tvec_sel[XLEN-1:2], 2'b00} +
                      ((tvec_sel[0] && intr) ? XLEN'({trap_cause[5:0], 2'b00}) : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstatus <= '0; medeleg <= '0; mideleg <= '0; mie <= '0; mtvec <= '0;
            mscratch <= '0; mepc <= '0; mcause <= '0; mtval <= '0; mip <= '0;
            mcycle <= '0; sscratch <= '0; sepc <= '0; scause <= '0; stval <= '0;
            stvec <= '0; satp <= '0;
            priv_q         <= PRIV_M;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            irq_pending    <= 1'b0;
        end else begin
            redirect_valid <= trap_valid || mret_ok || sret_ok;
            if (do_write && csr_addr == 12'hb00) mcycle <= wval;
            else                                 mcycle <= mcycle + XLEN'(1);

            if (trap_valid) begin
                redirect_pc <= target;
                if (deleg) begin
                    sepc          <= trap_pc;
                    scause        <= trap_cause;
                    stval         <= trap_tval;
                    mstatus[SPIE] <= mstatus[SIE];
                    mstatus[SIE]  <= 1'b0;
                    mstatus[SPP]  <= priv_q[0];
                    priv_q        <= PRIV_S;
                end else begin
                    mepc             <= trap_pc;
                    mcause           <= trap_cause;
                    mtval            <= trap_tval;
                    mstatus[MPIE]    <= mstatus[MIE];
                    mstatus[MIE]     <= 1'b0;
                    mstatus[12:11]   <= priv_q;
                    priv_q           <= PRIV_M;
                end
            end else if (mret_ok) begin
                redirect_pc    <= mepc;
                priv_q         <= mstatus[12:11];
                mstatus[MIE]   <= mstatus[MPIE];
                mstatus[MPIE]  <= 1'b1;
                mstatus[12:11] <= PRIV_U;
            end else if (sret_ok) begin
                redirect_pc   <= sepc;
                priv_q        <= {1'b0, mstatus[SPP]};
                mstatus[SIE]  <= mstatus[SPIE];
                mstatus[SPIE] <= 1'b1;
                mstatus[SPP]  <= 1'b0;
            end else if (do_write) begin
                case (csr_addr)
                    12'h300: mstatus  <= wval & MSTATUS_MASK;
                    12'h100: mstatus  <= (mstatus & ~SSTATUS_MASK) | (wval & SSTATUS_MASK);
                    12'h302: medeleg  <= wval & MEDELEG_MASK;
                    12'h303: mideleg  <= wval & MIDELEG_MASK;
                    12'h304: mie      <= wval;
                    12'h104: mie      <= (mie & ~mideleg) | (wval & mideleg);
                    12'h305: mtvec    <= tvec_fix(wval);
                    12'h105: stvec    <= tvec_fix(wval);
                    12'h340: mscratch <= wval;
                    12'h341: mepc     <= wval;
                    12'h342: mcause   <= wval;
                    12'h343: mtval    <= wval;
                    12'h344: mip      <= wval & MIP_MASK;
                    12'h144: mip      <= (mip & ~(mideleg & MIP_MASK)) | (wval & mideleg & MIP_MASK);
                    12'h140: sscratch <= wval;
                    12'h141: sepc     <= wval;
                    12'h142: scause   <= wval;
                    12'h143: stval    <= wval;
                    12'h180: satp     <= wval;
                    default: ;
                endcase
            end

            irq_pending <= ((|(mip_rd & mie & ~mideleg)) && (priv_q != PRIV_M || mstatus[MIE])) ||
                           ((|(mip_rd & mie & mideleg)) &&
                            (priv_q == PRIV_U || (priv_q == PRIV_S && mstatus[SIE])));
        end
    end

    assign priv      = priv_q;
    assign satp_q    = satp;
    assign mstatus_q = mstatus;
endmodule
